fifo_i2c_rx_pack: RTL



---
 rtl/fifo_i2c_rx_pack.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/fifo_i2c_rx_pack.sv
// Receive-side byte-to-word packing FIFO for the I2C peripheral.
// Bytes from the I2C engine are packed MSB-lane first into WIDTH_OUT words
// and buffered for the bus side. A flush pushes a partially filled word.
module fifo_i2c_rx_pack #(
    parameter int DEPTH     = 16,
    parameter int WIDTH_IN  = 8,
    parameter int WIDTH_OUT = 32,
    localparam int RATIO    = WIDTH_OUT / WIDTH_IN,
    localparam int LANE_W   = $clog2(RATIO),
    localparam int BYTES_W  = $clog2(RATIO) + 1,
    localparam int CNT_W    = $clog2(DEPTH + 1),
    localparam int PTR_W    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [WIDTH_IN-1:0]  data_in,
    input  logic                 flush,
    input  logic                 rd_en,
    output logic [WIDTH_OUT-1:0] data_out,
    output logic [BYTES_W-1:0]   dout_bytes,
    output logic                 dout_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 in_ready,
    output logic                 overflow,
    output logic [CNT_W-1:0]     count
);

    localparam int ENTRY_W = WIDTH_OUT + BYTES_W;

    // Packer state
    logic [WIDTH_OUT-1:0] pack_q, pack_d;
    logic [LANE_W-1:0]    lane_q, lane_d;
    logic                 flush_pend_q, flush_pend_d;
    logic                 overflow_q;

    // Storage state
    logic [ENTRY_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [WIDTH_OUT-1:0] data_out_q;
    logic [BYTES_W-1:0]   dout_bytes_q;
    logic                 dout_valid_q;

    // Combinational helpers
    logic                 full_w, empty_w, in_ready_w;
    logic                 last_lane, accept, complete, flush_act, push, pop;
    logic [BYTES_W-1:0]   lane_eff;
    logic [WIDTH_OUT-1:0] pack_eff;

    assign full_w     = (count_q == CNT_W'(DEPTH));
    assign empty_w    = (count_q == '0);
    assign last_lane  = (lane_q == LANE_W'(RATIO - 1));
    // A word can only be completed when there is room to push it.
    assign in_ready_w = !flush_pend_q && !(full_w && last_lane);
    assign accept     = wr_en && in_ready_w;
    assign complete   = accept && last_lane;

    // Word contents including a byte accepted this cycle.
    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
            assign pack_eff[WIDTH_OUT-1-gi*WIDTH_IN -: WIDTH_IN] =
                (accept && lane_q == LANE_W'(gi)) ? data_in
                                                  : pack_q[WIDTH_OUT-1-gi*WIDTH_IN -: WIDTH_IN];
        end
    endgenerate

    // Byte count including this cycle's accepted byte; equals RATIO on completion.
    assign lane_eff  = {1'b0, lane_q} + BYTES_W'(accept);
    // A (new or pending) flush only matters if a partial word remains.
    assign flush_act = (flush || flush_pend_q) && !complete && (lane_eff != '0);
    // Push gated by registered full: no pass-through when full.
    assign push      = complete || (flush_act && !full_w);
    assign pop       = rd_en && !empty_w;

    // Packer next state: clear on push, otherwise absorb byte and latch pending flush.
    always_comb begin
        pack_d       = pack_q;
        lane_d       = lane_q;
        flush_pend_d = flush_pend_q;
        if (push) begin
            pack_d       = '0;
            lane_d       = '0;
            flush_pend_d = 1'b0;
        end else begin
            if (accept) begin
                pack_d = pack_eff;
                lane_d = lane_eff[LANE_W-1:0];
            end
            if (flush_act) begin
                flush_pend_d = 1'b1;
            end
        end
    end

    // Occupancy next state; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Word storage write port (no reset so it maps to block RAM).
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {pack_eff, lane_eff};
        end
    end

    // State registers and registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack_q       <= '0;
            lane_q       <= '0;
            flush_pend_q <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_out_q   <= '0;
            dout_bytes_q <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            pack_q       <= pack_d;
            lane_q       <= lane_d;
            flush_pend_q <= flush_pend_d;
            count_q      <= count_d;
            dout_valid_q <= pop;
            if (wr_en && !in_ready_w) begin
                overflow_q <= 1'b1;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                {data_out_q, dout_bytes_q} <= mem[rd_ptr_q];
                rd_ptr_q                   <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    assign data_out   = data_out_q;
    assign dout_bytes = dout_bytes_q;
    assign dout_valid = dout_valid_q;
    assign full       = full_w;
    assign empty      = empty_w;
    assign in_ready   = in_ready_w;
    assign overflow   = overflow_q;
    assign count      = count_q;

endmodule
